mem_access_unit: RTL and testbench

- Load/store front end between the MIPS datapath (ALU result, rt data, control) and the word-wide data memory.
- Converts byte addresses into the memory's word-index address form.
- Performs byte/halfword/word load extraction with sign or zero extension.
- Performs sub-word stores as a stalled two-cycle read-modify-write, since the data memory only writes whole words; detects misaligned accesses.

---
 rtl/mem_access_unit.sv | 178 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Load/store front end between the MIPS datapath and a word-wide data
//   memory. Byte addresses are turned into word-index addresses, loads are
//   lane-extracted and sign/zero extended with no latency, and sub-word
//   stores are done as a stalled read-modify-write because the memory can
//   only write whole words. Misaligned accesses are suppressed and the first
//   one is recorded.
//
// Ports
//   i_clk           system clock, rising edge
//   i_reset         synchronous active-high reset
//   i_Address       byte address from the ALU
//   i_WriteData     store data (rt), sub-word data in the low bits
//   i_MemWrite      store request
//   i_MemRead       load request
//   i_AccessSize    00 byte, 01 halfword, 10/11 word
//   i_LoadUnsigned  zero-extend sub-word loads when 1
//   i_MemReadData   combinational read word from data memory
//   o_MemAddress    word-index address to data memory
//   o_MemWriteData  word written to data memory
//   o_MemWriteEn    data memory write strobe
//   o_MemReadEn     data memory read enable
//   o_ReadData      extended load result for writeback
//   o_Stall         holds the pipeline while a sub-word store is merging
//   o_AddrError     sticky misaligned-access flag
//   o_BadAddress    byte address of the first misaligned access
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] BASE_ADDRESS = 32'h10010000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [31:0]           i_Address,
    input  logic [DATA_WIDTH-1:0] i_WriteData,
    input  logic                  i_MemWrite,
    input  logic                  i_MemRead,
    input  logic [1:0]            i_AccessSize,
    input  logic                  i_LoadUnsigned,
    input  logic [DATA_WIDTH-1:0] i_MemReadData,
    output logic [31:0]           o_MemAddress,
    output logic [DATA_WIDTH-1:0] o_MemWriteData,
    output logic                  o_MemWriteEn,
    output logic                  o_MemReadEn,
    output logic [DATA_WIDTH-1:0] o_ReadData,
    output logic                  o_Stall,
    output logic                  o_AddrError,
    output logic [31:0]           o_BadAddress
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MERGE = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                r_state;
    logic [31:0]           r_addr;
    logic [15:0]           r_wdata;
    logic [1:0]            r_size;
    logic [DATA_WIDTH-1:0] r_merged;
    logic                  r_AddrError;
    logic [31:0]           r_BadAddress;

    logic                  w_isWord;
    logic                  w_isHalf;
    logic                  w_misaligned;
    logic                  w_idle;
    logic                  w_storeOk;
    logic                  w_startRmw;
    logic                  w_loadOk;
    logic [31:0]           w_selAddr;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_loadData;
    logic [DATA_WIDTH-1:0] w_mergeWord;

    // Reserved size 11 behaves as a word access.
    assign w_isWord     = i_AccessSize[1];
    assign w_isHalf     = (i_AccessSize == 2'b01);
    assign w_misaligned = (w_isHalf & i_Address[0]) | (w_isWord & (|i_Address[1:0]));

    // While reset is high the unit behaves as if idle, regardless of the
    // state register, so a pending RMW write can never escape.
    assign w_idle     = (r_state == IDLE) | i_reset;
    assign w_storeOk  = i_MemWrite & ~w_misaligned;
    assign w_startRmw = w_idle & ~i_reset & w_storeOk & ~w_isWord;
    assign w_loadOk   = i_MemRead & ~i_MemWrite & ~w_misaligned;

    // Once an RMW has started the memory address comes from the captured
    // byte address, so the pipeline inputs are free to change.
    assign w_selAddr    = w_idle ? i_Address : r_addr;
    assign o_MemAddress = BASE_ADDRESS + ((w_selAddr - BASE_ADDRESS) >> 2);

    assign o_MemWriteEn   = ~i_reset & (((r_state == IDLE) & w_storeOk & w_isWord) |
                                        (r_state == WRITE));
    assign o_MemWriteData = (r_state == WRITE) ? r_merged : i_WriteData;
    assign o_MemReadEn    = w_idle ? (i_MemRead | w_startRmw) : (r_state == MERGE);
    assign o_Stall        = w_startRmw | (~i_reset & (r_state == MERGE));
    assign o_AddrError    = r_AddrError;
    assign o_BadAddress   = r_BadAddress;

    // Load path: shift the addressed lane down to bit 0, then extend.
    assign w_shifted = i_MemReadData >> {i_Address[1:0], 3'b000};

    always_comb begin
        w_loadData = '0;
        if (w_idle && w_loadOk) begin
            case (i_AccessSize)
                2'b00:   w_loadData = {{(DATA_WIDTH-8){w_shifted[7] & ~i_LoadUnsigned}},
                                       w_shifted[7:0]};
                2'b01:   w_loadData = {{(DATA_WIDTH-16){w_shifted[15] & ~i_LoadUnsigned}},
                                       w_shifted[15:0]};
                default: w_loadData = i_MemReadData;
            endcase
        end
    end

    assign o_ReadData = w_loadData;

    // Replace the captured lane(s) of the word read back during MERGE.
    always_comb begin
        w_mergeWord = i_MemReadData;
        if (r_size == 2'b00) begin
            case (r_addr[1:0])
                2'd0:    w_mergeWord[7:0]   = r_wdata[7:0];
                2'd1:    w_mergeWord[15:8]  = r_wdata[7:0];
                2'd2:    w_mergeWord[23:16] = r_wdata[7:0];
                default: w_mergeWord[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_mergeWord[31:16] = r_wdata;
        end else begin
            w_mergeWord[15:0] = r_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= '0;
            r_merged     <= '0;
            r_AddrError  <= 1'b0;
            r_BadAddress <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_startRmw) begin
                        r_addr  <= i_Address;
                        r_wdata <= i_WriteData[15:0];
                        r_size  <= i_AccessSize;
                        r_state <= MERGE;
                    end
                end
                MERGE: begin
                    r_merged <= w_mergeWord;
                    r_state  <= WRITE;
                end
                WRITE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Only the first misaligned access is remembered.
            if ((r_state == IDLE) && (i_MemRead || i_MemWrite) && w_misaligned &&
                !r_AddrError) begin
                r_AddrError  <= 1'b1;
                r_BadAddress <= i_Address;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Self-checking bench for mem_access_unit. A small word memory is attached
//   to the DUT; a separate reference copy of that memory plus the error flag
//   form the behavioural model. Each transaction computes the per-cycle
//   expected outputs from the load/store rules, and one compare process
//   checks them on every falling edge. Directed transactions additionally
//   pin a few hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam logic [31:0] BASE = 32'h10010000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  AccessSize;
    logic        LoadUnsigned;
    logic [31:0] MemReadData;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWriteEn;
    logic        MemReadEn;
    logic [31:0] ReadData;
    logic        Stall;
    logic        AddrError;
    logic [31:0] BadAddress;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(32), .BASE_ADDRESS(BASE)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_Address      (Address),
        .i_WriteData    (WriteData),
        .i_MemWrite     (MemWrite),
        .i_MemRead      (MemRead),
        .i_AccessSize   (AccessSize),
        .i_LoadUnsigned (LoadUnsigned),
        .i_MemReadData  (MemReadData),
        .o_MemAddress   (MemAddress),
        .o_MemWriteData (MemWriteData),
        .o_MemWriteEn   (MemWriteEn),
        .o_MemReadEn    (MemReadEn),
        .o_ReadData     (ReadData),
        .o_Stall        (Stall),
        .o_AddrError    (AddrError),
        .o_BadAddress   (BadAddress)
    );

    // Data memory seen by the DUT (16 words at BASE), with a preload port.
    logic [31:0] tbMem [16];
    logic        loadEn = 1'b0;
    logic [3:0]  loadIdx;
    logic [31:0] loadWord;

    assign MemReadData = tbMem[MemAddress[3:0]];

    always @(posedge clk) begin
        if (loadEn)          tbMem[loadIdx] <= loadWord;
        else if (MemWriteEn) tbMem[MemAddress[3:0]] <= MemWriteData;
    end

    // Behavioural model state.
    logic [31:0] refMem [16];
    logic        modErr;
    logic [31:0] modBad;

    // Per-cycle expectations and their valid flags.
    logic        checkEn = 1'b0;
    logic [31:0] expAddr, expWdata, expRead, expBad;
    logic        expWe, expRe, expStall, expErr;
    logic        vAddr, vWdata, vRe, vRead, vErr;

    // Observations of the last transaction, for literal pins.
    logic [31:0] obsAddr, obsRead, obsWdata2;
    logic        obsWe, obsStall0, obsStall1, obsWe2;

    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("MemWriteEn", {31'b0, MemWriteEn}, {31'b0, expWe});
            checkOutput("Stall", {31'b0, Stall}, {31'b0, expStall});
            if (vAddr)  checkOutput("MemAddress", MemAddress, expAddr);
            if (vWdata) checkOutput("MemWriteData", MemWriteData, expWdata);
            if (vRe)    checkOutput("MemReadEn", {31'b0, MemReadEn}, {31'b0, expRe});
            if (vRead)  checkOutput("ReadData", ReadData, expRead);
            if (vErr) begin
                checkOutput("AddrError", {31'b0, AddrError}, {31'b0, expErr});
                checkOutput("BadAddress", BadAddress, expBad);
            end
        end
    end

    function automatic logic [31:0] loadVal(input logic [31:0] w, input int lane,
                                            input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        v = w >> (8 * lane);
        case (sz)
            2'b00: begin
                v = v & 32'h000000FF;
                if (!uns && v[7]) v = v | 32'hFFFFFF00;
            end
            2'b01: begin
                v = v & 32'h0000FFFF;
                if (!uns && v[15]) v = v | 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] wordAddr(input logic [31:0] a);
        return BASE + ((a - BASE) >> 2);
    endfunction

    task automatic scrambleInputs();
        Address      = $urandom;
        WriteData    = $urandom;
        MemRead      = 1'($urandom_range(0, 1));
        MemWrite     = 1'($urandom_range(0, 1));
        AccessSize   = 2'($urandom_range(0, 3));
        LoadUnsigned = 1'($urandom_range(0, 1));
    endtask

    task automatic preload(input int idx, input logic [31:0] w);
        checkEn  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        loadEn   = 1'b1;
        loadIdx  = 4'(idx);
        loadWord = w;
        refMem[idx] = w;
        @(posedge clk); #1;
        loadEn = 1'b0;
    endtask

    task automatic resetDut(input int cycles);
        reset = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0;
        Address = BASE; WriteData = '0; AccessSize = 2'b10; LoadUnsigned = 1'b0;
        expWe = 1'b0; expStall = 1'b0; expRe = 1'b0; vRe = 1'b1;
        expRead = '0; vRead = 1'b1; vAddr = 1'b0; vWdata = 1'b0; vErr = 1'b0;
        checkEn = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        modErr = 1'b0;
        modBad = '0;
    endtask

    // One load/store transaction; rstMerge asserts reset in the MERGE cycle.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                 input logic rstMerge);
        logic        mis, subword, wordSt;
        logic [31:0] off, mask, merged;
        int          idx, lane;
        mis     = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        off     = (a - BASE) >> 2;
        idx     = int'(off[3:0]);
        lane    = int'(a[1:0]);
        wordSt  = wr && !mis && sz[1];
        subword = wr && !mis && !sz[1];

        Address = a; WriteData = wd; MemWrite = wr; MemRead = rd;
        AccessSize = sz; LoadUnsigned = uns;
        expAddr = wordAddr(a); vAddr = 1'b1;
        expRe = rd || subword; vRe = 1'b1;
        expWe = wordSt; expWdata = wd; vWdata = wordSt;
        expStall = subword;
        expRead = (rd && !wr && !mis) ? loadVal(refMem[idx], lane, sz, uns) : 32'h0;
        vRead = 1'b1;
        expErr = modErr; expBad = modBad; vErr = 1'b1;
        checkEn = 1'b1;
        @(negedge clk);
        obsAddr = MemAddress; obsWe = MemWriteEn; obsRead = ReadData; obsStall0 = Stall;
        @(posedge clk); #1;
        if (wordSt) refMem[idx] = wd;
        if ((wr || rd) && mis && !modErr) begin
            modErr = 1'b1;
            modBad = a;
        end

        if (subword) begin
            // MERGE cycle: inputs are don't-care now.
            scrambleInputs();
            expErr = modErr; expBad = modBad;
            vRead = 1'b0; vWdata = 1'b0; expWe = 1'b0;
            if (rstMerge) begin
                reset = 1'b1;
                vAddr = 1'b0; expStall = 1'b0; expRe = MemRead;
                @(negedge clk);
                obsStall1 = Stall;
                @(posedge clk); #1;
                reset = 1'b0;
                modErr = 1'b0;
                modBad = '0;
                return;
            end
            expStall = 1'b1; expRe = 1'b1;
            @(negedge clk);
            obsStall1 = Stall;
            @(posedge clk); #1;

            // WRITE cycle.
            scrambleInputs();
            mask   = ((sz == 2'b00) ? 32'h000000FF : 32'h0000FFFF) << (8 * lane);
            merged = (refMem[idx] & ~mask) | ((wd << (8 * lane)) & mask);
            expWe = 1'b1; expWdata = merged; vWdata = 1'b1;
            expStall = 1'b0; vRe = 1'b0;
            @(negedge clk);
            obsWe2 = MemWriteEn; obsWdata2 = MemWriteData;
            @(posedge clk); #1;
            refMem[idx] = merged;
        end
    endtask

    initial begin
        logic        wr, rd, uns;
        logic [1:0]  sz;
        logic [31:0] a;

        modErr = 1'b0;
        modBad = '0;
        resetDut(2);
        checkOutput("rst AddrError", {31'b0, AddrError}, 32'h0);
        checkOutput("rst BadAddress", BadAddress, 32'h0);
        checkOutput("rst Stall", {31'b0, Stall}, 32'h0);

        for (int i = 0; i < 16; i++) preload(i, $urandom);

        // Word store, then load it back.
        applyStimulus(1, 0, 2'b10, 0, 32'h10010008, 32'hDEADBEEF, 0);
        checkOutput("sw MemAddress", obsAddr, 32'h10010002);
        checkOutput("sw MemWriteEn", {31'b0, obsWe}, 32'h1);
        checkOutput("sw Stall", {31'b0, obsStall0}, 32'h0);
        applyStimulus(0, 1, 2'b10, 0, 32'h10010008, 32'h0, 0);
        checkOutput("lw readback", obsRead, 32'hDEADBEEF);

        // Byte store read-modify-write.
        preload(2, 32'h11223344);
        applyStimulus(1, 0, 2'b00, 0, 32'h1001000A, 32'h000000AB, 0);
        checkOutput("sb Stall c0", {31'b0, obsStall0}, 32'h1);
        checkOutput("sb Stall c1", {31'b0, obsStall1}, 32'h1);
        checkOutput("sb WriteEn", {31'b0, obsWe2}, 32'h1);
        checkOutput("sb merged", obsWdata2, 32'h11AB3344);

        // Sign/zero extension.
        preload(3, 32'h8000F0FF);
        applyStimulus(0, 1, 2'b00, 0, 32'h1001000C, 32'h0, 0);
        checkOutput("lb lane0", obsRead, 32'hFFFFFFFF);
        applyStimulus(0, 1, 2'b00, 1, 32'h1001000C, 32'h0, 0);
        checkOutput("lbu lane0", obsRead, 32'h000000FF);
        applyStimulus(0, 1, 2'b01, 0, 32'h1001000E, 32'h0, 0);
        checkOutput("lh lane2", obsRead, 32'hFFFF8000);
        applyStimulus(0, 1, 2'b01, 1, 32'h1001000E, 32'h0, 0);
        checkOutput("lhu lane2", obsRead, 32'h00008000);

        // Misaligned accesses.
        applyStimulus(0, 1, 2'b10, 0, 32'h10010006, 32'h0, 0);
        checkOutput("misal lw ReadData", obsRead, 32'h0);
        checkOutput("misal AddrError", {31'b0, AddrError}, 32'h1);
        checkOutput("misal BadAddress", BadAddress, 32'h10010006);
        applyStimulus(1, 0, 2'b01, 0, 32'h10010003, 32'h1234, 0);
        checkOutput("misal sh WriteEn", {31'b0, obsWe}, 32'h0);
        checkOutput("misal sh Stall", {31'b0, obsStall0}, 32'h0);
        checkOutput("BadAddress kept", BadAddress, 32'h10010006);

        // Reset during MERGE aborts the store.
        applyStimulus(1, 0, 2'b01, 0, 32'h10010004, 32'h0000BEEF, 1);
        checkOutput("rstMerge Stall", {31'b0, obsStall1}, 32'h0);
        applyStimulus(0, 0, 2'b10, 0, 32'h10010004, 32'h0, 0);
        checkOutput("post-rst Stall", {31'b0, obsStall0}, 32'h0);
        checkOutput("post-rst WriteEn", {31'b0, obsWe}, 32'h0);
        checkOutput("post-rst AddrError", {31'b0, AddrError}, 32'h0);
        applyStimulus(1, 0, 2'b10, 0, 32'h10010010, 32'h12345678, 0);
        checkOutput("post-rst sw WriteEn", {31'b0, obsWe}, 32'h1);

        // Read and write together: store wins, no load data.
        applyStimulus(1, 1, 2'b10, 0, 32'h10010000, 32'h00000005, 0);
        checkOutput("rdwr WriteEn", {31'b0, obsWe}, 32'h1);
        checkOutput("rdwr ReadData", obsRead, 32'h0);
        applyStimulus(0, 1, 2'b10, 0, 32'h10010000, 32'h0, 0);
        checkOutput("rdwr readback", obsRead, 32'h00000005);

        // Address mapping wraps below the data segment.
        applyStimulus(0, 0, 2'b10, 0, 32'h00000008, 32'h0, 0);
        checkOutput("wrap MemAddress", obsAddr, 32'h4C00C002);

        // Randomized transactions, occasionally re-arming the error flag.
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 99) resetDut(1);
            wr  = 1'($urandom_range(0, 1));
            rd  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            a   = BASE + 32'($urandom_range(0, 63));
            applyStimulus(wr, rd, sz, uns, a, $urandom, 0);
        end

        // Final sweep: every word of memory must match the model.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 2'b10, 0, BASE + 32'(4 * i), 32'h0, 0);
        end

        checkEn = 1'b0;
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
